spram_march_bist: RTL and testbench



---
 rtl/spram_march_bist_if.sv | 14 +
 rtl/spram_march_bist.sv | 195 +++++++++++++++++++
 tb/tb_spram_march_bist.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/spram_march_bist_if.sv
// Word-wide single-port SRAM bus between the March BIST initiator and the SPRAM.
// The initiator drives the request side; the memory returns read data one cycle later.
interface spram_march_bist_if;
    localparam int unsigned AW = 22;
    localparam int unsigned DW = 32;

    logic [3:0]    mem_wen;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport master (output mem_wen, output mem_addr, output mem_wdata, input mem_rdata);
    modport slave  (input mem_wen, input mem_addr, input mem_wdata, output mem_rdata);
endinterface

// File: rtl/spram_march_bist.sv
// Four-element March BIST for the SPRAM word window: M0 w, M1 r/w~, M2 (down) r~/w, M3 r.
// Reports pass/fail with the first failing address and the word read there.
module spram_march_bist #(
    parameter int unsigned WORDS   = 16384,
    parameter logic [31:0] PATTERN = 32'h5555_5555
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      start,
    input  logic                      abort,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic [21:0]               fail_addr,
    output logic [31:0]               fail_data,
    spram_march_bist_if.master        bus
);
    localparam int unsigned AW      = 22;
    localparam int unsigned DW      = 32;
    localparam logic [AW-1:0] LAST  = AW'(WORDS - 1);
    localparam logic [3:0]  WEN_ALL = 4'hF;

    typedef enum logic [2:0] {IDLE, M0, M1, M2, M3, DRAIN, FIN} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [3:0]    wen_q, wen_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          wr_q, wr_d;
    logic [AW-1:0] prev_q, prev_d;
    logic          prev_vld_q, prev_vld_d;
    logic          busy_d, done_d, pass_d;
    logic [AW-1:0] fail_addr_d;
    logic [DW-1:0] fail_data_d;
    logic          mismatch_c;
    logic [AW-1:0] chk_addr_c;

    assign bus.mem_addr  = addr_q;
    assign bus.mem_wen   = wen_q;
    assign bus.mem_wdata = wdata_q;

    // State and registered bus/status outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wen_q      <= '0;
            wdata_q    <= '0;
            wr_q       <= 1'b0;
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_addr  <= '0;
            fail_data  <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wen_q      <= wen_d;
            wdata_q    <= wdata_d;
            wr_q       <= wr_d;
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
            busy       <= busy_d;
            done       <= done_d;
            pass       <= pass_d;
            fail_addr  <= fail_addr_d;
            fail_data  <= fail_data_d;
        end
    end

    // Next-state, next-bus and read-check logic
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wen_d       = '0;
        wdata_d     = '0;
        wr_d        = 1'b0;
        prev_d      = prev_q;
        prev_vld_d  = 1'b0;
        busy_d      = busy;
        done_d      = done;
        pass_d      = pass;
        fail_addr_d = fail_addr;
        fail_data_d = fail_data;
        mismatch_c  = 1'b0;
        chk_addr_c  = addr_q;

        // Read data arriving now belongs to the read issued one cycle earlier
        case (state_q)
            M1:      mismatch_c = wr_q && (bus.mem_rdata != PATTERN);
            M2:      mismatch_c = wr_q && (bus.mem_rdata != ~PATTERN);
            M3, DRAIN: begin
                mismatch_c = prev_vld_q && (bus.mem_rdata != PATTERN);
                chk_addr_c = prev_q;
            end
            default: mismatch_c = 1'b0;
        endcase

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = M0;
                    addr_d      = '0;
                    wen_d       = WEN_ALL;
                    wdata_d     = PATTERN;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    fail_addr_d = '0;
                    fail_data_d = '0;
                end
            end
            M0: begin
                if (addr_q == LAST) begin
                    state_d = M1;
                    addr_d  = '0;
                end else begin
                    addr_d  = addr_q + AW'(1);
                    wen_d   = WEN_ALL;
                    wdata_d = PATTERN;
                end
            end
            M1: begin
                if (!wr_q) begin
                    wr_d    = 1'b1;
                    wen_d   = WEN_ALL;
                    wdata_d = ~PATTERN;
                end else if (!mismatch_c) begin
                    if (addr_q == LAST) state_d = M2;
                    else                addr_d  = addr_q + AW'(1);
                end
            end
            M2: begin
                if (!wr_q) begin
                    wr_d    = 1'b1;
                    wen_d   = WEN_ALL;
                    wdata_d = PATTERN;
                end else if (!mismatch_c) begin
                    if (addr_q == '0) state_d = M3;
                    else              addr_d  = addr_q - AW'(1);
                end
            end
            M3: begin
                prev_d     = addr_q;
                prev_vld_d = 1'b1;
                if (!mismatch_c) begin
                    if (addr_q == LAST) begin
                        state_d = DRAIN;
                        addr_d  = '0;
                    end else begin
                        addr_d  = addr_q + AW'(1);
                    end
                end
            end
            DRAIN: begin
                if (!mismatch_c) begin
                    state_d = FIN;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = 1'b1;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // First mismatch ends the run; the write on the bus this cycle still lands
        if (mismatch_c) begin
            state_d     = FIN;
            addr_d      = '0;
            wen_d       = '0;
            wdata_d     = '0;
            wr_d        = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            pass_d      = 1'b0;
            fail_addr_d = chk_addr_c;
            fail_data_d = bus.mem_rdata;
        end

        if (abort) begin
            state_d    = IDLE;
            addr_d     = '0;
            wen_d      = '0;
            wdata_d    = '0;
            wr_d       = 1'b0;
            prev_vld_d = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b0;
            pass_d     = 1'b0;
        end
    end
endmodule

// File: tb/tb_spram_march_bist.sv
// Scoreboard bench for spram_march_bist: a faulty behavioural SPRAM, an abstract March
// reference model that predicts every bus cycle and the final verdict, and a bus monitor.
module tb_spram_march_bist;
    localparam int W = 16;
    localparam logic [31:0] P = 32'h5555_5555;

    typedef struct {
        int          kind;   // 0 read, 1 write, 2 drain
        logic [21:0] addr;
        logic [31:0] data;
    } op_t;

    logic        clk, resetn, start, abort, busy, done, pass;
    logic [21:0] fail_addr;
    logic [31:0] fail_data;

    spram_march_bist_if bif();

    spram_march_bist #(.WORDS(W), .PATTERN(P)) dut (
        .clk(clk), .resetn(resetn), .start(start), .abort(abort),
        .busy(busy), .done(done), .pass(pass),
        .fail_addr(fail_addr), .fail_data(fail_data), .bus(bif)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int busy_cnt = 0;

    // fault: 0 none, 1 stuck bit, 2 write to fa+1 copies into fa, 3 bit fb of fa cannot fall
    int   ft, fa, fb;
    logic fv;
    logic [31:0] spram   [W];
    logic [31:0] ref_mem [W];
    op_t         exp_q[$];
    logic        exp_pass;
    logic [21:0] exp_faddr, cur_fa;
    logic [31:0] exp_fdata, cur_fd;
    int          exp_len;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [31:0] next_word(input logic [31:0] old, input int t,
                                              input int wa, input logic [31:0] wd);
        logic [31:0] nw;
        nw = old;
        if (t == wa) begin
            nw = wd;
            if (ft == 1 && t == fa) nw[fb] = fv;
            if (ft == 3 && t == fa && old[fb] && !wd[fb]) nw[fb] = 1'b1;
        end else if (ft == 2 && t == fa && wa == fa + 1) begin
            nw = wd;
        end
        return nw;
    endfunction

    // Behavioural SPRAM: registered read, byte write enables, fault injection
    always @(posedge clk) begin
        logic [31:0] wd;
        int a;
        a = int'(bif.mem_addr[3:0]);
        bif.mem_rdata <= spram[a];
        if (bif.mem_wen != 4'h0) begin
            wd = spram[a];
            for (int b = 0; b < 4; b++)
                if (bif.mem_wen[b]) wd[8*b +: 8] = bif.mem_wdata[8*b +: 8];
            for (int t = 0; t < W; t++) spram[t] = next_word(spram[t], t, a, wd);
        end
    end

    function automatic void push_op(input int kind, input int a, input logic [31:0] d);
        op_t op;
        op.kind = kind;
        op.addr = 22'(a);
        op.data = d;
        exp_q.push_back(op);
    endfunction

    function automatic void ref_write(input int a, input logic [31:0] d);
        for (int t = 0; t < W; t++) ref_mem[t] = next_word(ref_mem[t], t, a, d);
    endfunction

    // Reference March run on ref_mem: every bus cycle in order plus the expected verdict
    task automatic model_run();
        logic [31:0] got;
        bit failed;
        failed = 1'b0;
        exp_q.delete();
        exp_faddr = '0;
        exp_fdata = '0;
        for (int a = 0; a < W; a++) begin
            push_op(1, a, P);
            ref_write(a, P);
        end
        for (int a = 0; a < W && !failed; a++) begin
            push_op(0, a, 0);
            got = ref_mem[a];
            push_op(1, a, ~P);
            ref_write(a, ~P);
            if (got != P) begin failed = 1'b1; exp_faddr = 22'(a); exp_fdata = got; end
        end
        for (int a = W - 1; a >= 0 && !failed; a--) begin
            push_op(0, a, 0);
            got = ref_mem[a];
            push_op(1, a, P);
            ref_write(a, P);
            if (got != ~P) begin failed = 1'b1; exp_faddr = 22'(a); exp_fdata = got; end
        end
        for (int a = 0; a < W && !failed; a++) begin
            push_op(0, a, 0);
            got = ref_mem[a];
            if (got != P) begin
                failed = 1'b1; exp_faddr = 22'(a); exp_fdata = got;
                if (a < W - 1) push_op(0, a + 1, 0);
                else           push_op(2, 0, 0);
            end
        end
        if (!failed) push_op(2, 0, 0);
        exp_pass = !failed;
        exp_len  = exp_q.size();
    endtask

    // Bus monitor: every busy cycle must match the next predicted operation
    always @(negedge clk) begin
        op_t op;
        if (resetn && busy) begin
            busy_cnt++;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL bus_cycle_beyond_model: busy cycle %0d has no expected op", busy_cnt);
            end else begin
                op = exp_q.pop_front();
                case (op.kind)
                    1: check("bus_write", {bif.mem_wen, bif.mem_addr, bif.mem_wdata},
                             {4'hF, op.addr, op.data});
                    0: check("bus_read", {bif.mem_wen, bif.mem_addr}, {4'h0, op.addr});
                    default: check("bus_drain_wen", bif.mem_wen, 4'h0);
                endcase
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pass"}, pass, 0);
        check({tag, "_fail_addr"}, fail_addr, 0);
        check({tag, "_fail_data"}, fail_data, 0);
        check({tag, "_mem_wen"}, bif.mem_wen, 0);
        check({tag, "_mem_addr"}, bif.mem_addr, 0);
        check({tag, "_mem_wdata"}, bif.mem_wdata, 0);
    endtask

    task automatic do_run(input int f_t, input int f_a, input int f_b, input logic f_v,
                          input int abort_at, input bit noisy);
        int base;
        bit finished;
        ft = f_t; fa = f_a; fb = f_b; fv = f_v;
        ref_mem = spram;
        model_run();
        base = busy_cnt;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        cur_fa = '0;
        cur_fd = '0;
        if (abort_at > 0) begin
            repeat (abort_at - 1) @(negedge clk);
            abort = 1'b1;
            start = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            start = 1'b0;
            check("abort_busy", busy, 0);
            check("abort_done", done, 0);
            check("abort_pass", pass, 0);
            check("abort_mem_wen", bif.mem_wen, 0);
            check("abort_fail_addr", fail_addr, cur_fa);
            check("abort_cycles", busy_cnt - base, abort_at);
            exp_q.delete();
            return;
        end
        finished = 1'b0;
        for (int i = 0; i < 400 && !finished; i++) begin
            @(negedge clk);
            if (!busy) finished = 1'b1;
            else start = noisy && ($urandom_range(0, 3) == 0);
        end
        start = 1'b0;
        check("run_terminated", finished, 1);
        check("busy_cycles", busy_cnt - base, exp_len);
        check("model_ops_left", exp_q.size(), 0);
        if (!exp_pass) begin cur_fa = exp_faddr; cur_fd = exp_fdata; end
        check("done_at_end", done, 1);
        check("pass_verdict", pass, exp_pass);
        check("fail_addr", fail_addr, cur_fa);
        check("fail_data", fail_data, cur_fd);
        check("idle_bus", {bif.mem_wen, bif.mem_addr, bif.mem_wdata}, 0);
        repeat (2) @(negedge clk);
        check("done_held", done, 1);
    endtask

    initial begin
        int bad;
        int t;
        resetn = 1'b0; start = 1'b0; abort = 1'b0;
        ft = 0; fa = 0; fb = 0; fv = 1'b0;
        cur_fa = '0; cur_fd = '0;
        for (int i = 0; i < W; i++) spram[i] = 32'h0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        resetn = 1'b1;
        @(negedge clk);

        do_run(0, 0, 0, 1'b0, 0, 1'b0);
        bad = 0;
        for (int i = 0; i < W; i++) if (spram[i] != P) bad++;
        check("final_mem_words_not_pattern", bad, 0);

        do_run(1, 5, 0, 1'b1, 0, 1'b0);
        do_run(1, 5, 0, 1'b0, 0, 1'b0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("idle_abort_done", done, 0);
        check("idle_abort_keeps_fail_addr", fail_addr, cur_fa);
        check("idle_abort_keeps_fail_data", fail_data, cur_fd);
        do_run(2, 8, 0, 1'b0, 0, 1'b0);
        do_run(3, 15, 1, 1'b0, 0, 1'b0);
        for (int r = 0; r < 8; r++) begin
            t = $urandom_range(1, 3);
            do_run(t, (t == 2) ? $urandom_range(0, W - 2) : $urandom_range(0, W - 1),
                   $urandom_range(0, 31), 1'($urandom_range(0, 1)), 0, 1'b0);
        end

        do_run(0, 0, 0, 1'b0, 40, 1'b0);
        do_run(0, 0, 0, 1'b0, 0, 1'b0);
        do_run(0, 0, 0, 1'b0, $urandom_range(2, 6 * W), 1'b0);
        do_run(0, 0, 0, 1'b0, 0, 1'b1);

        // Reset asserted in the middle of M2
        ft = 0;
        ref_mem = spram;
        model_run();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (52) @(negedge clk);
        #2 resetn = 1'b0;
        #1 check_all_zero("async_reset");
        @(negedge clk);
        resetn = 1'b1;
        exp_q.delete();
        cur_fa = '0;
        cur_fd = '0;
        repeat (6) @(negedge clk);
        check("post_reset_idle_busy", busy, 0);
        check("post_reset_idle_wen", bif.mem_wen, 0);
        do_run(0, 0, 0, 1'b0, 0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
